sa_seq_ctrl: RTL and testbench
==============================

// Module: sa_seq_ctrl
// PURPOSE
//  Sequencer for the 8x4 signed-MAC systolic array. On start it clears the array and fetches K operand
//  vectors from a registered operand store, then drives them into the array row/column edges with
//  diagonal skew. It drains the pipeline, reads back every accumulator and streams the results as
//  bytes to the 8N1 UART transmitter. Sits between top-level control, the operand store, the array and uart_tx_8n1.
// PARAMETERS
//  NUM_ROWS  8   array rows (activation lanes)
//  NUM_COLS  4   array columns (weight lanes)
//  DATA_W    8   operand width, signed
//  ACC_W     32  accumulator width; multiple of 8
//  K_DEPTH   8   inner-product length = operand vectors per run; >=1
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   reset, asynchronous, active-high
//  start      in   1                   run request; sampled only in IDLE
//  busy       out  1                   high in every state except IDLE
//  done       out  1                   1-cycle pulse on the SEND->IDLE transition
//  op_addr    out  $clog2(K_DEPTH)+1   operand-store address; data returns next cycle
//  op_act     in   NUM_ROWS*DATA_W     activation vector, row r = [r*DATA_W +: DATA_W]
//  op_wt      in   NUM_COLS*DATA_W     weight vector, col c = [c*DATA_W +: DATA_W]
//  arr_clr    out  1                   synchronous clear for all MAC accumulators/pipes
//  arr_act    out  NUM_ROWS*DATA_W     skewed activations into column 0
//  arr_wt     out  NUM_COLS*DATA_W     skewed weights into row 0
//  res_sel    out  $clog2(NUM_ROWS*NUM_COLS)   accumulator select, index = row*NUM_COLS+col
//  res_data   in   ACC_W               selected accumulator, combinational from res_sel
//  tx_byte    out  8                   byte to UART
//  tx_send    out  1                   1-cycle send strobe
//  tx_done    in   1                   UART byte-complete pulse
// BEHAVIOUR
//  Reset: state IDLE; busy, done, arr_clr, tx_send = 0; op_addr, res_sel, tx_byte = 0; skew lines = 0.
//  FSM: IDLE -start-> CLEAR (1 cyc, arr_clr=1) -> FEED (K_DEPTH+1 cyc) -> DRAIN (NUM_ROWS+NUM_COLS-1 cyc)
//       -> LOAD -> SEND -> LOAD ... -> IDLE.
//  FEED: op_addr = 0..K_DEPTH-1 on cycles 0..K_DEPTH-1. Vector k is valid on cycle k+1. Lanes not holding
//        valid data inject 0. Row r activation is delayed r cycles; col c weight is delayed c cycles.
//  DRAIN: inject zeros only; after it, accumulator (r,c) = sum_k act[k][r]*wt[k][c] (signed, wraps at ACC_W).
//  LOAD: latch res_data at res_sel into shift buffer (1 cyc).
//  SEND: ACC_W/8 bytes, LSB first. For each byte: tx_byte set and tx_send pulsed for 1 cycle,
//        then wait for tx_done; the next strobe comes no earlier than the cycle after tx_done.
//  res_sel increments 0..NUM_ROWS*NUM_COLS-1; after the last byte of the last result: done pulse, IDLE.
//  start while busy: ignored (not queued). tx_done outside a wait: ignored.
//  start and reset together: reset wins. Reset mid-run: immediate IDLE; no done; arr_clr is not asserted.
//  K_DEPTH=1: FEED is 2 cycles.
//  tx_done in the same cycle as tx_send: counts as the wait condition satisfied.
// CONFIGURATION
//  SA_SEQ_CHECKSUM_EN defined:
//    after the final result byte, one extra byte is sent = XOR of all result bytes in the run;
//    done pulses after its tx_done.
//  SA_SEQ_CHECKSUM_EN undefined:
//    no trailer byte; total bytes per run = NUM_ROWS*NUM_COLS*ACC_W/8.
// STRUCTURE
//  sa_seq_pkg: state enum (IDLE, CLEAR, FEED, DRAIN, LOAD, SEND), byte-count and cycle-count width localparams.
//  Sub-module sa_skew_line: one instance per lane.
//    Parameterised DEPTH shift register; DEPTH=0 is pass-through.
//    Async reset to 0; zero-fill when its input is invalid.
// TESTING
//  1. Reset, no start for 20 cycles -> busy=0, tx_send never high, all outputs 0.
//  2. K=8, act all 1, wt all 2 -> every accumulator 16; UART stream 0x10,0,0,0 repeated 32 times; done once.
//  3. Signed check: act=-3 (0xFD), wt=5, K=8 -> each result 0xFFFFFF88, bytes 88 FF FF FF.
//  4. tx_done delayed 10 cycles per byte -> exactly one tx_send per tx_done, none while waiting.
//  5. Assert reset during FEED, then start -> result identical to an uninterrupted run; no stale done.
//  6. start pulsed during SEND -> ignored. With SA_SEQ_CHECKSUM_EN, run of test 2 -> trailer byte 0x00.

Source files
------------

// File: rtl/sa_seq_pkg.sv
// Shared state encoding and width helpers for the systolic-array sequencer.
package sa_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_LOAD  = 3'd4;
  localparam state_t ST_SEND  = 3'd5;

  // Width of a counter that must hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sa_seq_if.sv
// Control, operand-store, array and UART signals of the sequencer, grouped as one bus.
interface sa_seq_if #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_DEPTH  = 8
);
  localparam int AW = $clog2(K_DEPTH) + 1;
  localparam int SW = $clog2(NUM_ROWS * NUM_COLS);

  logic                         start;
  logic                         busy;
  logic                         done;
  logic [AW-1:0]                op_addr;
  logic [NUM_ROWS*DATA_W-1:0]   op_act;
  logic [NUM_COLS*DATA_W-1:0]   op_wt;
  logic                         arr_clr;
  logic [NUM_ROWS*DATA_W-1:0]   arr_act;
  logic [NUM_COLS*DATA_W-1:0]   arr_wt;
  logic [SW-1:0]                res_sel;
  logic [ACC_W-1:0]             res_data;
  logic [7:0]                   tx_byte;
  logic                         tx_send;
  logic                         tx_done;

  modport master (
    input  start, op_act, op_wt, res_data, tx_done,
    output busy, done, op_addr, arr_clr, arr_act, arr_wt, res_sel, tx_byte, tx_send
  );

  modport slave (
    output start, op_act, op_wt, res_data, tx_done,
    input  busy, done, op_addr, arr_clr, arr_act, arr_wt, res_sel, tx_byte, tx_send
  );

endinterface

// File: rtl/sa_skew_line.sv
// Per-lane skew delay: DEPTH-stage shift register, zero-filled while the input is invalid.
module sa_skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         valid,
  output logic [W-1:0] dout
);
  logic [W-1:0] din_gated;

  assign din_gated = valid ? din : '0;

  generate
    if (DEPTH == 0) begin : g_pass
      // no stages, so clock and reset have nothing to drive
      logic unused_clk_rst;
      assign unused_clk_rst = clk | reset;
      assign dout = din_gated;
    end else begin : g_pipe
      logic [W-1:0] pipe [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din_gated;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for the signed-MAC systolic array: clear, skewed feed, drain, UART readout.
// Optional checksum trailer byte when SA_SEQ_CHECKSUM_EN is defined.
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | one cycle of arr_clr
//   FEED  | fetch K vectors and inject them skewed (K+1 cycles)
//   DRAIN | inject zeros until the last MAC completes
//   LOAD  | latch selected accumulator
//   SEND  | stream bytes LSB first, one per tx_done
module sa_seq_ctrl
  import sa_seq_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_DEPTH  = 8
) (
  input  logic     clk,
  input  logic     reset,
  sa_seq_if.master bus
);
  localparam int AW     = $clog2(K_DEPTH) + 1;
  localparam int NRES   = NUM_ROWS * NUM_COLS;
  localparam int SW     = $clog2(NRES);
  localparam int NBYTES = ACC_W / 8;
  localparam int BW     = cnt_width(NBYTES);
  localparam int CW     = cnt_width(K_DEPTH + NUM_ROWS + NUM_COLS);

  localparam logic [CW-1:0] FEED_LAST  = CW'(K_DEPTH);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(NUM_ROWS + NUM_COLS - 2);
  localparam logic [SW-1:0] RES_LAST   = SW'(NRES - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(NBYTES - 1);

  state_t                     state;
  logic [CW-1:0]              cyc_cnt;
  logic [SW-1:0]              res_sel;
  logic [BW-1:0]              byte_cnt;
  logic [ACC_W-1:0]           shift_buf;
  logic                       waiting;
  logic                       tx_send_r;
  logic [7:0]                 tx_byte_r;
  logic                       done_r;
  logic                       feed_valid;
  logic [NUM_ROWS*DATA_W-1:0] act_skew;
  logic [NUM_COLS*DATA_W-1:0] wt_skew;
`ifdef SA_SEQ_CHECKSUM_EN
  logic [7:0]                 csum;
  logic                       trailer;
`endif

  // Store data lags the address by one cycle, so lanes are valid on FEED cycles 1..K.
  assign feed_valid  = (state == ST_FEED) && (cyc_cnt != FEED_LAST);
  assign bus.op_addr = (state == ST_FEED && cyc_cnt != '0) ? AW'(FEED_LAST - cyc_cnt) : '0;

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_act
      sa_skew_line #(.DEPTH(r), .W(DATA_W)) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   (bus.op_act[r*DATA_W +: DATA_W]),
        .valid (feed_valid),
        .dout  (act_skew[r*DATA_W +: DATA_W])
      );
    end
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_wt
      sa_skew_line #(.DEPTH(c), .W(DATA_W)) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   (bus.op_wt[c*DATA_W +: DATA_W]),
        .valid (feed_valid),
        .dout  (wt_skew[c*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cyc_cnt   <= '0;
      res_sel   <= '0;
      byte_cnt  <= '0;
      shift_buf <= '0;
      waiting   <= 1'b0;
      tx_send_r <= 1'b0;
      tx_byte_r <= '0;
      done_r    <= 1'b0;
`ifdef SA_SEQ_CHECKSUM_EN
      csum      <= '0;
      trailer   <= 1'b0;
`endif
    end else begin
      tx_send_r <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_CLEAR;
            res_sel <= '0;
`ifdef SA_SEQ_CHECKSUM_EN
            csum    <= '0;
            trailer <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          state   <= ST_FEED;
          cyc_cnt <= FEED_LAST;
        end
        ST_FEED: begin
          if (cyc_cnt == '0) begin
            state   <= ST_DRAIN;
            cyc_cnt <= DRAIN_LAST;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cyc_cnt == '0) state <= ST_LOAD;
          else               cyc_cnt <= cyc_cnt - 1'b1;
        end
        ST_LOAD: begin
          shift_buf <= bus.res_data;
          byte_cnt  <= BYTE_LAST;
          waiting   <= 1'b0;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (!waiting) begin
            tx_byte_r <= shift_buf[7:0];
            tx_send_r <= 1'b1;
            waiting   <= 1'b1;
`ifdef SA_SEQ_CHECKSUM_EN
            csum      <= csum ^ shift_buf[7:0];
`endif
          end else if (bus.tx_done) begin
            waiting   <= 1'b0;
            shift_buf <= shift_buf >> 8;
            if (byte_cnt != '0) begin
              byte_cnt <= byte_cnt - 1'b1;
            end else if (res_sel != RES_LAST) begin
              res_sel <= res_sel + 1'b1;
              state   <= ST_LOAD;
            end else begin
`ifdef SA_SEQ_CHECKSUM_EN
              if (!trailer) begin
                // reuse the byte path for a single trailer byte
                trailer   <= 1'b1;
                shift_buf <= ACC_W'(csum);
              end else begin
                state   <= ST_IDLE;
                res_sel <= '0;
                done_r  <= 1'b1;
              end
`else
              state   <= ST_IDLE;
              res_sel <= '0;
              done_r  <= 1'b1;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_r;
  assign bus.arr_clr = (state == ST_CLEAR);
  assign bus.arr_act = act_skew;
  assign bus.arr_wt  = wt_skew;
  assign bus.res_sel = res_sel;
  assign bus.tx_byte = tx_byte_r;
  assign bus.tx_send = tx_send_r;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with an operand store, a systolic-array model and a UART responder.
module tb_sa_seq_ctrl;
  localparam int NR = 8;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AC = 32;
  localparam int KD = 8;
  localparam int NRES = NR * NC;
`ifdef SA_SEQ_CHECKSUM_EN
  localparam int NB = NRES * (AC / 8) + 1;
`else
  localparam int NB = NRES * (AC / 8);
`endif
  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sa_seq_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_W(DW), .ACC_W(AC), .K_DEPTH(KD)) bus ();

  sa_seq_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_W(DW), .ACC_W(AC), .K_DEPTH(KD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int miscompares = 0;

  logic signed [7:0] act_mem [KD][NR];
  logic signed [7:0] wt_mem  [KD][NC];
  logic signed [7:0] a_reg   [NR][NC];
  logic signed [7:0] w_reg   [NR][NC];
  logic [31:0]       acc_m   [NR][NC];

  logic [7:0] rx_q [$];
  int   send_cnt = 0, rsp_cnt = 0, viol_cnt = 0, done_cnt = 0;
  int   tx_lat = 1;
  logic tx_inject = 1'b0;
  logic pend = 1'b0;
  int   wcnt = 0;
  logic model_done;
  int   last_base = 0;

  // operand store: registered read
  always @(posedge clk) begin
    int a;
    a = int'(bus.op_addr);
    for (int r = 0; r < NR; r++) bus.op_act[r*DW +: DW] <= (a < KD) ? act_mem[a][r] : 8'h00;
    for (int c = 0; c < NC; c++) bus.op_wt[c*DW +: DW]  <= (a < KD) ? wt_mem[a][c]  : 8'h00;
  end

  // systolic array: activations move right, weights move down
  always @(posedge clk) begin
    logic signed [7:0]  ai, wi;
    logic signed [31:0] p;
    int cl, rl;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        cl = (c == 0) ? 0 : c - 1;
        rl = (r == 0) ? 0 : r - 1;
        ai = (c == 0) ? bus.arr_act[r*DW +: DW] : a_reg[r][cl];
        wi = (r == 0) ? bus.arr_wt[c*DW +: DW]  : w_reg[rl][c];
        p  = ai * wi;
        if (bus.arr_clr) begin
          a_reg[r][c] <= '0;
          w_reg[r][c] <= '0;
          acc_m[r][c] <= '0;
        end else begin
          a_reg[r][c] <= ai;
          w_reg[r][c] <= wi;
          acc_m[r][c] <= acc_m[r][c] + p;
        end
      end
    end
  end

  always_comb bus.res_data = acc_m[int'(bus.res_sel) / NC][int'(bus.res_sel) % NC];

  // UART responder: tx_done tx_lat cycles after each strobe (same cycle when tx_lat is 0)
  assign model_done  = (pend && wcnt == 0) || (tx_lat == 0 && bus.tx_send);
  assign bus.tx_done = model_done | tx_inject;

  always @(posedge clk) begin
    if (bus.tx_send) begin
      send_cnt++;
      rx_q.push_back(bus.tx_byte);
      if (pend) viol_cnt++;
      if (tx_lat > 0) begin
        pend <= 1'b1;
        wcnt <= tx_lat - 1;
      end
    end else if (pend) begin
      if (wcnt == 0) pend <= 1'b0;
      else           wcnt <= wcnt - 1;
    end
    if (model_done) rsp_cnt++;
    if (bus.done)   done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int mode);
    for (int k = 0; k < KD; k++) begin
      for (int r = 0; r < NR; r++)
        act_mem[k][r] = 8'((mode == 0) ? 1 : (mode == 1) ? -3 : k * 3 - r * 5);
      for (int c = 0; c < NC; c++)
        wt_mem[k][c] = 8'((mode == 0) ? 2 : (mode == 1) ? 5 : 7 - 2 * k + c);
    end
  endtask

  function automatic logic [31:0] exp_acc(input int r, input int c);
    logic signed [31:0] s, p;
    s = 0;
    for (int k = 0; k < KD; k++) begin
      p = act_mem[k][r] * wt_mem[k][c];
      s = s + p;
    end
    return s;
  endfunction

  function automatic logic [31:0] rx_word(input int idx);
    if (idx + 3 < rx_q.size())
      return {rx_q[idx+3], rx_q[idx+2], rx_q[idx+1], rx_q[idx]};
    return 'x;
  endfunction

  task automatic run_case(input string tag, input int lat, input bit mid_start, input bit inject_done);
    int cyc, base, s0, r0, d0, v0;
    bit fired;
    logic [7:0]  x;
    logic [31:0] e;
    tx_lat = lat;
    base = rx_q.size();
    last_base = base;
    s0 = send_cnt; r0 = rsp_cnt; d0 = done_cnt; v0 = viol_cnt;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 0;
    fired = 1'b0;
    while (done_cnt == d0 && cyc < LIMIT) begin
      if (mid_start && !fired && rx_q.size() - base == 5) begin
        bus.start = 1'b1;
        fired = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tx_inject = inject_done && cyc == 6;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    tx_inject = 1'b0;
    chk({tag, "_timeout"}, 64'(cyc < LIMIT), 64'd1);
    repeat (30) @(negedge clk);
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_bytes"}, 64'(rx_q.size() - base), 64'(NB));
    chk({tag, "_strobes"}, 64'(send_cnt - s0), 64'(NB));
    chk({tag, "_acks"}, 64'(rsp_cnt - r0), 64'(NB));
    chk({tag, "_early_strobe"}, 64'(viol_cnt - v0), 64'd0);
    x = 8'h00;
    for (int i = 0; i < NRES; i++) begin
      e = exp_acc(i / NC, i % NC);
      x = x ^ e[7:0] ^ e[15:8] ^ e[23:16] ^ e[31:24];
      chk($sformatf("%s_res%0d", tag, i), 64'(rx_word(base + 4 * i)), 64'(e));
    end
`ifdef SA_SEQ_CHECKSUM_EN
    chk({tag, "_trailer"}, 64'((base + NB - 1 < rx_q.size()) ? rx_q[base + NB - 1] : 8'hxx), 64'(x));
`endif
  endtask

  initial begin
    int d0, b0, s0;
    bus.start = 1'b0;
    set_data(0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    s0 = send_cnt;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_tx_send_cnt", 64'(send_cnt - s0), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd0);
    chk("t1_op_addr", 64'(bus.op_addr), 64'd0);
    chk("t1_arr_clr", 64'(bus.arr_clr), 64'd0);
    chk("t1_tx_byte", 64'(bus.tx_byte), 64'd0);
    chk("t1_res_sel", 64'(bus.res_sel), 64'd0);
    chk("t1_arr_act", 64'(bus.arr_act), 64'd0);
    chk("t1_arr_wt", 64'(bus.arr_wt), 64'd0);

    // all-ones times all-twos, stray tx_done during FEED
    set_data(0);
    run_case("t2", 1, 1'b0, 1'b1);
    chk("t2_word0_const", 64'(rx_word(last_base)), 64'h10);
    chk("t2_word31_const", 64'(rx_word(last_base + 124)), 64'h10);
`ifdef SA_SEQ_CHECKSUM_EN
    chk("t2_trailer_const", 64'(rx_q[last_base + NB - 1]), 64'h00);
`endif

    // signed operands
    set_data(1);
    run_case("t3", 2, 1'b0, 1'b0);
    chk("t3_word0_const", 64'(rx_word(last_base)), 64'hFFFF_FF88);
    chk("t3_byte0_const", 64'(rx_q[last_base]), 64'h88);

    // varied operands exercise the skew; slow and zero-latency UART
    set_data(2);
    run_case("t4_slow", 10, 1'b0, 1'b0);
    run_case("t4_same_cycle", 0, 1'b0, 1'b0);

    // reset in the middle of FEED, then a clean run
    tx_lat = 1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_in_feed", 64'(bus.busy && bus.op_addr != '0), 64'd1);
    d0 = done_cnt;
    b0 = rx_q.size();
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(bus.busy), 64'd0);
    chk("t5_rst_arr_clr", 64'(bus.arr_clr), 64'd0);
    chk("t5_rst_op_addr", 64'(bus.op_addr), 64'd0);
    chk("t5_rst_arr_act", 64'(bus.arr_act), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_no_bytes", 64'(rx_q.size() - b0), 64'd0);
    run_case("t5_rerun", 1, 1'b0, 1'b0);

    // start during SEND is dropped
    set_data(0);
    run_case("t6", 3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
